ram_ctrl: RTL
=============

RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 Parameter AW, default 8, meaning word-address width of the backing array (2**AW 32-bit words).
REQ-002 Parameter LATENCY, default 4, meaning the number of clock edges from request acceptance to the array access; legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset; one clock, synchronous, active-low.
REQ-005 req_valid  input  1  cache-side request present.
REQ-006 req_ready  output  1  controller can accept a request this cycle.
REQ-007 req_wr  input  1  1 = write, 0 = read; sampled at acceptance.
REQ-008 req_addr  input  32  word address; only bits [AW-1:0] used, upper bits ignored.
REQ-009 req_wdata  input  32  write data; sampled at acceptance.
REQ-010 resp_valid  output  1  one-cycle completion pulse, for reads and writes.
REQ-011 resp_rdata  output  32  read data; valid while resp_valid=1.

Function
REQ-012 Storage SHALL be a 2**AW x 32 array with no reset of its contents.
REQ-013 FSM SHALL have exactly three states: IDLE, WAIT, DONE.
REQ-014 req_ready SHALL be combinational, equal to (state==IDLE), and independent of req_valid.
REQ-015 Acceptance SHALL occur at an edge where state==IDLE and req_valid=1.
REQ-016 On acceptance, req_wr, req_addr[AW-1:0], and req_wdata SHALL be latched, cnt SHALL load LATENCY-1, and the state SHALL become WAIT.
REQ-017 In WAIT with cnt!=0, cnt SHALL decrement by 1 per edge; input changes SHALL have no effect.
REQ-018 In WAIT with cnt==0, the next edge SHALL perform the latched operation and enter DONE.
REQ-019 On that edge, a write SHALL store the latched data and load resp_rdata with 32'h0.
REQ-020 On that edge, a read SHALL load resp_rdata with the array word at the latched address.
REQ-021 resp_valid SHALL be a registered output, 1 exactly while state==DONE.
REQ-022 DONE SHALL return to IDLE unconditionally on the next edge; no backpressure on the response.
REQ-023 Timing: acceptance at edge E0 SHALL cause the array access at edge E(LATENCY) and resp_valid high during the cycle between E(LATENCY) and E(LATENCY+1).
REQ-024 Timing: req_ready SHALL rise after E(LATENCY+1), giving a minimum request spacing of LATENCY+2 edges.
REQ-025 resp_rdata SHALL hold its last value outside DONE until the next completion.
REQ-026 Requests SHALL be strictly serialized, so a read after a write to the same address returns the written data.
REQ-027 req_valid asserted while req_ready=0 SHALL be ignored, with no queuing; the requester must hold req_valid until acceptance.
REQ-028 With LATENCY=1, cnt SHALL load 0, so WAIT lasts exactly one edge.
REQ-029 Addresses differing only above bit AW-1 SHALL alias to the same word.
REQ-030 cnt SHALL be 4 bits wide and SHALL never wrap below 0.

Reset
REQ-031 While rst_n=0 at an edge, state SHALL become IDLE, cnt 0, resp_valid 0, and resp_rdata 32'h0.
REQ-032 req_ready SHALL be 1 in the cycle after the reset edge.
REQ-033 Reset during WAIT SHALL abort the operation; a pending write whose access edge has not occurred SHALL leave the array unchanged.
REQ-034 Reset during DONE SHALL drop resp_valid at that edge.
REQ-035 A req_valid sampled at an edge with rst_n=0 SHALL NOT be accepted.

Verification (AW=8, LATENCY=4)
REQ-036 Write addr 0x05 data 0xDEADBEEF -> req_ready low next cycle; resp_valid pulses 4 edges after acceptance for one cycle; resp_rdata=0x0; req_ready high again 5 edges after acceptance.
REQ-037 Then read addr 0x05 -> resp_valid 4 edges after acceptance with resp_rdata=0xDEADBEEF.
REQ-038 Hold req_valid=1 continuously with alternating write and read to addr 0x10 -> acceptances exactly 6 edges apart; no request lost or duplicated; reads return the preceding write.
REQ-039 Write 0x11111111 to addr 0x105, then read addr 0x005 -> 0x11111111 (alias).
REQ-040 Write addr 0x07 data 0xA5A5A5A5 complete, then write addr 0x07 data 0x12345678 with rst_n=0 two edges after acceptance -> outputs reset next cycle; subsequent read of 0x07 returns 0xA5A5A5A5.
REQ-041 Re-instantiate with LATENCY=1; write then read addr 0x00 -> resp_valid 1 edge after each acceptance; read returns the written data.

Source files
------------

// File: rtl/ram_ctrl.sv
// Single-port RAM controller: accepts one request at a time and performs the
// array access after a fixed LATENCY, then pulses resp_valid for one cycle.
module ram_ctrl #(
    parameter int unsigned AW      = 8,
    parameter int unsigned LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata
);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q;
    logic            wr_q;
    logic [AW-1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q;
    logic [31:0]     mem [0:(2**AW)-1];
    logic            accept;
    logic            access;
    logic            unused_addr;

    // Address bits above AW-1 alias onto the same word.
    assign unused_addr = ^req_addr[31:AW];

    assign accept = (state_q == StIdle) && req_valid;
    assign access = (state_q == StWait) && (cnt_q == 4'd0);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (req_valid) state_d = StWait;
            StWait: if (cnt_q == 4'd0) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs; resp_valid is registered since it decodes the state register.
    always_comb begin
        req_ready  = (state_q == StIdle);
        resp_valid = (state_q == StDone);
        resp_rdata = rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            if (accept) begin
                cnt_q   <= 4'(LATENCY - 1);
                wr_q    <= req_wr;
                addr_q  <= req_addr[AW-1:0];
                wdata_q <= req_wdata;
            end else if ((state_q == StWait) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (access) begin
                rdata_q <= wr_q ? 32'h0 : mem[addr_q];
            end
        end
    end

    // Array contents are never reset; a reset on the access edge suppresses the write.
    always_ff @(posedge clk) begin
        if (rst_n && access && wr_q) begin
            mem[addr_q] <= wdata_q;
        end
    end

endmodule
